pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit, the next generation of the plain PC register in the microprocessor datapath. Holds the current fetch address and, under a per-cycle opcode, advances sequentially, branches PC-relative, jumps absolute, or performs call/return through an internal return-address stack (RAS). Sits between the control unit, which drives `op`/`en`, and instruction memory, which consumes `pc`.

## Interface
- `WIDTH`, 32: address width in bits.
- `STEP`, 4: sequential increment, a byte count; must be < 2^WIDTH.
- `RESET_VEC`, 0: value loaded into `pc` on reset.
- `RAS_DEPTH`, 8: return-address stack entries; power of two, ≥ 2.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  1 = execute `op` this cycle; 0 = stall, all state held.
- `op`  in  3  operation code, see Operation.
- `offset`  in  WIDTH  signed two's-complement branch displacement.
- `target`  in  WIDTH  absolute jump/call destination.
- `clr_err`  in  1  clears the sticky error flags.
- `pc`  out  WIDTH  registered current PC.
- `pc_next`  out  WIDTH  combinational value `pc` will take at next edge.
- `ras_count`  out  $clog2(RAS_DEPTH)+1  valid RAS entries, 0..RAS_DEPTH.
- `ras_empty`, `ras_full`  out  1 each  `ras_count`==0 / ==RAS_DEPTH.
- `ovf`  out  1  sticky: CALL issued while RAS full.
- `unf`  out  1  sticky: RET issued while RAS empty.

## Operation
- Opcodes:
  - 000 SEQ: `pc+STEP`.
  - 001 BR: `pc+offset`.
  - 010 JMP: `target`.
  - 011 CALL: push `pc+STEP`; `pc<=target`.
  - 100 RET: pop; `pc<=`popped value.
  - 101 HOLD: `pc` unchanged.
  - 110/111: reserved, behave as SEQ.
- Arithmetic is modulo 2^WIDTH. Wrap-around is silent, with no flag. `offset` is added as a WIDTH-bit value, so sign handling is implicit.
- The RAS is a circular buffer with a top pointer.
  - CALL when full: the push overwrites the oldest entry, `ras_count` stays RAS_DEPTH, and `ovf` is set.
  - RET when empty: `pc<=RESET_VEC`, the pointer and count are unchanged, and `unf` is set.
- `en`=0: `op` is ignored. `pc`, the RAS, and `ras_count` hold. `pc_next`=`pc`.
- `clr_err` clears `ovf`/`unf` regardless of `en`. If an error event and `clr_err` occur in the same cycle, the flag is set: the set wins.
- Reset values: `pc`=RESET_VEC, `ras_count`=0, `ovf`=`unf`=0. The contents of RAS storage are don't-care.

## Timing
- One-cycle latency: the `op` sampled at edge N is reflected in `pc` and RAS outputs after edge N.
- `pc_next` is combinational from `pc`, `op`, `en`, `offset`, `target`, and the RAS top. It is valid in the same cycle.
- `rst` has priority over `en`, `op`, and `clr_err`.
- Reset asserted mid call sequence discards the whole stack: count goes to 0 in the next cycle.
- Back-to-back CALL/RET on consecutive cycles must work with no bubble. A RET immediately after a CALL returns the address pushed by that CALL.
- Flags are registered: `ovf`/`unf` go high the cycle after the offending edge.

## Structure
- Shared package `pc_pkg`:
  - opcode localparams `OP_SEQ`, `OP_BR`, `OP_JMP`, `OP_CALL`, `OP_RET`, `OP_HOLD`;
  - a 3-bit `pc_op_t` typedef.
  - The control unit imports the same package.
- Sub-module `ras_stack #(WIDTH, RAS_DEPTH)`:
  - inputs `push`, `pop`, `din`;
  - outputs `top`, `count`, `full`, `empty`;
  - implements the circular-overwrite push.
- `pc_unit` holds the PC register, next-PC mux, and flag logic.

## Test plan
Parameters: WIDTH=32, STEP=4, RESET_VEC=0x100, RAS_DEPTH=4.
1. Reset, then 3 SEQ: `pc` = 0x100 → 0x104 → 0x108 → 0x10C. `ras_count`=0, flags 0.
2. At `pc`=0x10C:
   - BR `offset`=0xFFFFFFF4 (−12) → `pc`=0x100.
   - JMP `target`=0xFFFFFFFC, then SEQ → `pc`=0x0: wrap, no flag.
3. At `pc`=0x100:
   - CALL `target`=0x400 → `pc`=0x400, `ras_count`=1.
   - CALL 0x800 → `pc`=0x800, count=2.
   - RET → `pc`=0x404, count=1.
   - RET → `pc`=0x104, count=0.
4. Overflow: five CALLs (targets 0x1000..0x5000) from `pc`=0x100.
   - After the fifth: `ovf`=1, count=4.
   - Four RETs return 0x5000+... in LIFO order: 0x4004, 0x3004, 0x2004, 0x1004. The original 0x104 is lost.
   - A fifth RET gives `pc`=0x100 and `unf`=1.
5. Stall: `en`=0 for 3 cycles with `op`=CALL → `pc`, count unchanged, `pc_next`=`pc`. `clr_err` during the stall clears `ovf`/`unf` on the next edge.
6. Reset mid-operation: after 2 CALLs, assert `rst` together with `op`=RET → `pc`=0x100, count=0, flags 0.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: opcodes shared by the program-counter unit and the control unit
package pc_pkg;
    typedef logic [2:0] pc_op_t;
    localparam pc_op_t OP_SEQ  = 3'b000;
    localparam pc_op_t OP_BR   = 3'b001;
    localparam pc_op_t OP_JMP  = 3'b010;
    localparam pc_op_t OP_CALL = 3'b011;
    localparam pc_op_t OP_RET  = 3'b100;
    localparam pc_op_t OP_HOLD = 3'b101;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; a push while full overwrites the oldest entry
module ras_stack #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [AW-1:0]    ptr;
    logic             do_pop;
    assign full   = count == CW'(RAS_DEPTH);
    assign empty  = count == '0;
    assign top    = mem[ptr - 1'b1];
    // popping an empty stack leaves pointer and count untouched
    assign do_pop = pop && !empty;
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr   <= ptr + 1'b1;
            count <= full ? count : count + 1'b1;
        end else if (do_pop) begin
            ptr   <= ptr - 1'b1;
            count <= count - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[ptr] <= din;
    end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with sequential/branch/jump/call/return and return-address stack
module pc_unit
    import pc_pkg::*;
#(
    parameter int                WIDTH     = 32,
    parameter int                STEP      = 4,
    parameter logic [WIDTH-1:0]  RESET_VEC = '0,
    parameter int                RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  pc_op_t                       op,
    input  logic [WIDTH-1:0]             offset,
    input  logic [WIDTH-1:0]             target,
    input  logic                         clr_err,
    output logic [WIDTH-1:0]             pc,
    output logic [WIDTH-1:0]             pc_next,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         ovf,
    output logic                         unf
);
    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] ras_top;
    logic             push;
    logic             pop;
    assign pc_seq = pc + WIDTH'(STEP);
    assign push   = en && op == OP_CALL;
    assign pop    = en && op == OP_RET;
    ras_stack #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_seq),
        .top   (ras_top),
        .count (ras_count),
        .full  (ras_full),
        .empty (ras_empty)
    );
    always_comb begin
        pc_next = pc_seq;
        if (!en) pc_next = pc;
        else begin
            case (op)
                OP_BR:   pc_next = pc + offset;
                OP_JMP:  pc_next = target;
                OP_CALL: pc_next = target;
                OP_RET:  pc_next = ras_empty ? RESET_VEC : ras_top;
                OP_HOLD: pc_next = pc;
                default: pc_next = pc_seq;
            endcase
        end
    end
    // an error event in the same cycle as clr_err keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= RESET_VEC;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            pc  <= pc_next;
            ovf <= (push && ras_full) ? 1'b1 : clr_err ? 1'b0 : ovf;
            unf <= (pop && ras_empty) ? 1'b1 : clr_err ? 1'b0 : unf;
        end
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scoreboard bench for pc_unit (WIDTH=32, STEP=4, RESET_VEC=0x100, RAS_DEPTH=4)
module tb_pc_unit;
    import pc_pkg::*;
    typedef struct {
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    pc_op_t      op = OP_SEQ;
    logic [31:0] offset = '0;
    logic [31:0] target = '0;
    logic        clr_err = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [2:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;
    logic        ovf;
    logic        unf;
    int          compared = 0;
    int          mismatched = 0;
    exp_t        sb[$];
    pc_unit #(.WIDTH(32), .STEP(4), .RESET_VEC(32'h100), .RAS_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .op        (op),
        .offset    (offset),
        .target    (target),
        .clr_err   (clr_err),
        .pc        (pc),
        .pc_next   (pc_next),
        .ras_count (ras_count),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ovf       (ovf),
        .unf       (unf)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    // drive one cycle, check pc_next before the edge, then check registered state after it
    task automatic step(input string tag, input logic r, input logic e, input pc_op_t o,
                        input logic [31:0] off, input logic [31:0] tgt, input logic clr,
                        input logic [31:0] epc, input logic [2:0] ecnt, input logic eo, input logic eu);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; op = o; offset = off; target = tgt; clr_err = clr;
        sb.push_back('{pc: epc, cnt: ecnt, ovf: eo, unf: eu});
        #1;
        if (!r) chk({tag, ".pc_next"}, pc_next, epc);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({tag, ".pc"}, pc, x.pc);
        chk({tag, ".cnt"}, 32'(ras_count), 32'(x.cnt));
        chk({tag, ".flags"}, {30'd0, ovf, unf}, {30'd0, x.ovf, x.unf});
        chk({tag, ".fe"}, {30'd0, ras_full, ras_empty}, {30'd0, x.cnt == 3'd4, x.cnt == 3'd0});
    endtask
    initial begin
        step("reset", 1, 0, OP_SEQ, 0, 0, 0, 32'h100, 0, 0, 0);
        step("seq1", 0, 1, OP_SEQ, 0, 0, 0, 32'h104, 0, 0, 0);
        step("seq2", 0, 1, OP_SEQ, 0, 0, 0, 32'h108, 0, 0, 0);
        step("seq3", 0, 1, OP_SEQ, 0, 0, 0, 32'h10C, 0, 0, 0);
        step("br_neg", 0, 1, OP_BR, 32'hFFFFFFF4, 0, 0, 32'h100, 0, 0, 0);
        step("jmp_hi", 0, 1, OP_JMP, 0, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 0, 0, 0);
        step("seq_wrap", 0, 1, OP_SEQ, 0, 0, 0, 32'h0, 0, 0, 0);
        step("rsvd6", 0, 1, 3'b110, 0, 0, 0, 32'h4, 0, 0, 0);
        step("hold", 0, 1, OP_HOLD, 0, 0, 0, 32'h4, 0, 0, 0);
        step("jmp100", 0, 1, OP_JMP, 0, 32'h100, 0, 32'h100, 0, 0, 0);
        step("call400", 0, 1, OP_CALL, 0, 32'h400, 0, 32'h400, 1, 0, 0);
        step("call800", 0, 1, OP_CALL, 0, 32'h800, 0, 32'h800, 2, 0, 0);
        step("ret_a", 0, 1, OP_RET, 0, 0, 0, 32'h404, 1, 0, 0);
        step("ret_b", 0, 1, OP_RET, 0, 0, 0, 32'h104, 0, 0, 0);
        step("jmp100b", 0, 1, OP_JMP, 0, 32'h100, 0, 32'h100, 0, 0, 0);
        step("c1000", 0, 1, OP_CALL, 0, 32'h1000, 0, 32'h1000, 1, 0, 0);
        step("c2000", 0, 1, OP_CALL, 0, 32'h2000, 0, 32'h2000, 2, 0, 0);
        step("c3000", 0, 1, OP_CALL, 0, 32'h3000, 0, 32'h3000, 3, 0, 0);
        step("c4000", 0, 1, OP_CALL, 0, 32'h4000, 0, 32'h4000, 4, 0, 0);
        step("c5000", 0, 1, OP_CALL, 0, 32'h5000, 0, 32'h5000, 4, 1, 0);
        step("r4004", 0, 1, OP_RET, 0, 0, 0, 32'h4004, 3, 1, 0);
        step("r3004", 0, 1, OP_RET, 0, 0, 0, 32'h3004, 2, 1, 0);
        step("r2004", 0, 1, OP_RET, 0, 0, 0, 32'h2004, 1, 1, 0);
        step("r1004", 0, 1, OP_RET, 0, 0, 0, 32'h1004, 0, 1, 0);
        step("r_unf", 0, 1, OP_RET, 0, 0, 0, 32'h100, 0, 1, 1);
        step("stall1", 0, 0, OP_CALL, 0, 32'h900, 0, 32'h100, 0, 1, 1);
        step("stall2", 0, 0, OP_CALL, 0, 32'h900, 0, 32'h100, 0, 1, 1);
        step("stall_clr", 0, 0, OP_CALL, 0, 32'h900, 1, 32'h100, 0, 0, 0);
        step("cb2b_call", 0, 1, OP_CALL, 0, 32'h200, 0, 32'h200, 1, 0, 0);
        step("cb2b_ret", 0, 1, OP_RET, 0, 0, 0, 32'h104, 0, 0, 0);
        step("call_a", 0, 1, OP_CALL, 0, 32'h200, 0, 32'h200, 1, 0, 0);
        step("call_b", 0, 1, OP_CALL, 0, 32'h300, 0, 32'h300, 2, 0, 0);
        step("rst_mid", 1, 1, OP_RET, 0, 0, 0, 32'h100, 0, 0, 0);
        step("unf_clr", 0, 1, OP_RET, 0, 0, 1, 32'h100, 0, 0, 1);
        step("clr_only", 0, 1, OP_SEQ, 0, 0, 1, 32'h104, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
